// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg: shared game state encodings, widths and default enemy count.
package game_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WAVE_CLEAR = 2'd2, OVER = 2'd3} state_t;
  localparam int NUM_ENEMY1_DEF = 6;
  localparam int SCORE_W = 16;
  localparam int WAVE_W = 8;
endpackage

// File: rtl/game_sequencer_edge_popcount.sv
// edge_popcount: counts enemies whose dead flag rose this cycle.
module edge_popcount #(
  parameter int NUM_ENEMY1 = 6
) (
  input  logic [NUM_ENEMY1-1:0] cur,
  input  logic [NUM_ENEMY1-1:0] prev,
  output logic [3:0]            count
);
  always_comb begin
    count = 4'd0;
    for (int i = 0; i < NUM_ENEMY1; i++) count = count + 4'(cur[i] & ~prev[i]);
  end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game flow FSM tracking score, lives and waves.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int NUM_ENEMY1   = NUM_ENEMY1_DEF,
  parameter int START_LIVES  = 3,
  parameter int CLEAR_FRAMES = 60
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  frame_tick,
  input  logic                  start_btn,
  input  logic [NUM_ENEMY1-1:0] enemy_dead,
  input  logic                  ship_hit,
  output logic                  game_active,
  output logic                  wave_init,
  output logic [SCORE_W-1:0]    score,
  output logic [1:0]            lives,
  output logic [WAVE_W-1:0]     wave,
  output logic [1:0]            state
);
  state_t st, st_n;
  logic [SCORE_W-1:0] score_n;
  logic [SCORE_W:0] sum;
  logic [1:0] lives_n;
  logic [WAVE_W-1:0] wave_n;
  logic [15:0] cnt, cnt_n;
  logic armed, btn_q, press, init_n;
  logic [NUM_ENEMY1-1:0] dead_prev;
  logic [3:0] kills;
  edge_popcount #(.NUM_ENEMY1(NUM_ENEMY1)) u_pop (.cur(enemy_dead), .prev(dead_prev), .count(kills));
  assign press = start_btn & ~btn_q;
  assign sum = {1'b0, score} + 17'(kills);
  assign state = st;
  always_comb begin
    st_n = st;
    score_n = score;
    lives_n = lives;
    wave_n = wave;
    cnt_n = cnt;
    init_n = 1'b0;
    case (st)
      IDLE: if (press) begin
        st_n = PLAY;
        score_n = '0;
        lives_n = 2'(START_LIVES);
        wave_n = 8'd1;
        init_n = 1'b1;
      end
      PLAY: begin
        score_n = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        lives_n = ship_hit ? lives - 2'd1 : lives;
        // a final hit outranks a simultaneous wave clear
        if (ship_hit && lives == 2'd1) st_n = OVER;
        else if (armed && &enemy_dead) begin
          st_n = WAVE_CLEAR;
          cnt_n = 16'(CLEAR_FRAMES);
        end
      end
      WAVE_CLEAR: if (frame_tick) begin
        cnt_n = cnt - 16'(cnt != 16'd0);
        if (cnt <= 16'd1) begin
          st_n = PLAY;
          wave_n = &wave ? wave : wave + 8'd1;
          init_n = 1'b1;
        end
      end
      default: if (press) st_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      st <= IDLE;
      score <= '0;
      lives <= '0;
      wave <= '0;
      cnt <= '0;
      armed <= 1'b0;
      btn_q <= 1'b0;
      dead_prev <= '0;
      game_active <= 1'b0;
      wave_init <= 1'b0;
    end else begin
      st <= st_n;
      score <= score_n;
      lives <= lives_n;
      wave <= wave_n;
      cnt <= cnt_n;
      armed <= (st == PLAY) & (armed | frame_tick);
      btn_q <= start_btn;
      dead_prev <= enemy_dead;
      game_active <= (st_n == PLAY);
      wave_init <= init_n;
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed self-checking bench for game_sequencer.
module tb_game_sequencer;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0;
  logic start_btn = 1'b0;
  logic [5:0] enemy_dead = '0;
  logic ship_hit = 1'b0;
  logic game_active, wave_init;
  logic [15:0] score;
  logic [1:0] lives;
  logic [7:0] wave;
  logic [1:0] state;
  int tests = 0;
  int fails = 0;

  game_sequencer dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .start_btn(start_btn),
    .enemy_dead(enemy_dead), .ship_hit(ship_hit), .game_active(game_active),
    .wave_init(wave_init), .score(score), .lives(lives), .wave(wave), .state(state)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic ga, input logic wi,
                         input logic [15:0] sc, input logic [1:0] lv, input logic [7:0] wv);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".game_active"}, 32'(game_active), 32'(ga));
    chk({tag, ".wave_init"}, 32'(wave_init), 32'(wi));
    chk({tag, ".score"}, 32'(score), 32'(sc));
    chk({tag, ".lives"}, 32'(lives), 32'(lv));
    chk({tag, ".wave"}, 32'(wave), 32'(wv));
  endtask

  initial begin
    cyc(2);
    chk_all("reset", 2'd0, 1'b0, 1'b0, 16'd0, 2'd0, 8'd0);
    resetn = 1'b1;
    start_btn = 1'b1;
    cyc();
    chk_all("start", 2'd1, 1'b1, 1'b1, 16'd0, 2'd3, 8'd1);
    cyc();
    chk_all("start_held", 2'd1, 1'b1, 1'b0, 16'd0, 2'd3, 8'd1);
    start_btn = 1'b0;
    enemy_dead = 6'b000111;
    cyc();
    chk("multikill", 32'(score), 32'd3);
    cyc();
    chk("multikill_hold", 32'(score), 32'd3);
    for (int i = 0; i < 21843; i++) begin
      enemy_dead = (i % 2 == 0) ? 6'b111000 : 6'b000111;
      cyc();
    end
    chk("pump", 32'(score), 32'hFFFC);
    enemy_dead = 6'b000000;
    cyc();
    enemy_dead = 6'b000011;
    cyc();
    chk("sat_fffe", 32'(score), 32'hFFFE);
    enemy_dead = 6'b011100;
    cyc();
    chk("sat_ffff", 32'(score), 32'hFFFF);
    enemy_dead = 6'b000011;
    cyc();
    chk("sat_hold", 32'(score), 32'hFFFF);
    enemy_dead = 6'b111111;
    cyc();
    chk("unarmed_all_dead", 32'(state), 32'd1);
    frame_tick = 1'b1;
    cyc();
    chk("arming_edge", 32'(state), 32'd1);
    frame_tick = 1'b0;
    cyc();
    chk("wave_clear.state", 32'(state), 32'd2);
    chk("wave_clear.game_active", 32'(game_active), 32'd0);
    for (int i = 0; i < 59; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
    chk("clear_59", 32'(state), 32'd2);
    chk("clear_59.wave_init", 32'(wave_init), 32'd0);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk_all("clear_done", 2'd1, 1'b1, 1'b1, 16'hFFFF, 2'd3, 8'd2);
    cyc();
    chk("clear_pulse_end", 32'(wave_init), 32'd0);
    cyc(2);
    chk("stale_dead_ignored", 32'(state), 32'd1);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    chk("wave_clear2", 32'(state), 32'd2);
    for (int i = 0; i < 30; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
    chk("mid_clear", 32'(state), 32'd2);
    resetn = 1'b0;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk_all("reset_mid", 2'd0, 1'b0, 1'b0, 16'd0, 2'd0, 8'd0);
    enemy_dead = 6'b000000;
    resetn = 1'b1;
    cyc();
    chk_all("post_reset", 2'd0, 1'b0, 1'b0, 16'd0, 2'd0, 8'd0);
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    chk_all("restart", 2'd1, 1'b1, 1'b1, 16'd0, 2'd3, 8'd1);
    ship_hit = 1'b1;
    cyc();
    chk("hit1", 32'(lives), 32'd2);
    cyc();
    chk("hit2", 32'(lives), 32'd1);
    chk("hit2.state", 32'(state), 32'd1);
    ship_hit = 1'b0;
    enemy_dead = 6'b011111;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("five_kills", 32'(score), 32'd5);
    ship_hit = 1'b1;
    enemy_dead = 6'b111111;
    cyc();
    chk_all("death_priority", 2'd3, 1'b0, 1'b0, 16'd6, 2'd0, 8'd1);
    cyc();
    chk_all("hit_in_over", 2'd3, 1'b0, 1'b0, 16'd6, 2'd0, 8'd1);
    ship_hit = 1'b0;
    start_btn = 1'b1;
    cyc();
    chk_all("over_to_idle", 2'd0, 1'b0, 1'b0, 16'd6, 2'd0, 8'd1);
    cyc();
    chk("held_no_restart", 32'(state), 32'd0);
    start_btn = 1'b0;
    cyc();
    start_btn = 1'b1;
    cyc();
    chk_all("second_press", 2'd1, 1'b1, 1'b1, 16'd0, 2'd3, 8'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The module SHALL have these parameters:
- NUM_ENEMY1, default 6: number of enemy slots.
- START_LIVES, default 3: lives loaded at game start, range 1..3.
- CLEAR_FRAMES, default 60: frame ticks spent in WAVE_CLEAR.
REQ-002 The module SHALL have these ports:
- clock  in  1: single system clock; all state updates on its rising edge.
- resetn  in  1: reset, synchronous and active-low.
- frame_tick  in  1: one-cycle pulse per video frame.
- start_btn  in  1: raw start button level.
- enemy_dead  in  NUM_ENEMY1: per-enemy dead flags.
- ship_hit  in  1: one-cycle pulse when the ship is hit.
- game_active  out  1: enables ship, bullet and enemy motion.
- wave_init  out  1: one-cycle pulse that re-initialises enemies.
- score  out  16: kill count.
- lives  out  2: remaining lives.
- wave  out  8: current wave number.
- state  out  2: current FSM state.

Function
REQ-003 The FSM SHALL have four states with these encodings: IDLE=0, PLAY=1, WAVE_CLEAR=2, OVER=3.
REQ-004 start_btn SHALL be registered once, and a press SHALL be its rising edge (current=1, previous=0); a held button SHALL count as one press.
REQ-005 IDLE:
- A press SHALL move the FSM to PLAY.
- In the same edge it SHALL set score=0, lives=START_LIVES, wave=1 and drive wave_init=1 for exactly one cycle.
REQ-006 game_active SHALL be a registered output equal to 1 only while state==PLAY; it follows a state change with zero added cycles.
REQ-007 PLAY, scoring:
- Each cycle, score SHALL add the popcount of (enemy_dead & ~enemy_dead_prev).
- Addition SHALL saturate at 16'hFFFF.
- enemy_dead_prev SHALL be a register of enemy_dead, updated every cycle in all states.
REQ-008 PLAY, lives: ship_hit SHALL decrement lives.
- If lives==1 when ship_hit arrives, lives SHALL become 0 and the FSM SHALL go to OVER.
- ship_hit outside PLAY SHALL be ignored.
REQ-009 PLAY, arming: an armed flag SHALL clear on entry to PLAY and set on the first frame_tick seen in PLAY. While the flag is clear, the all-dead check SHALL be suppressed so that stale dead flags present at wave_init are not misread.
REQ-010 PLAY, wave clear: if armed and every enemy_dead bit is 1, the FSM SHALL go to WAVE_CLEAR and load a frame counter with CLEAR_FRAMES.
REQ-011 Simultaneous events in PLAY:
- The score update of REQ-007 SHALL still apply.
- A lives-to-0 hit SHALL take priority over the wave-clear transition (go to OVER).
- A non-final hit together with all-dead SHALL decrement lives and go to WAVE_CLEAR.
REQ-012 WAVE_CLEAR:
- The frame counter SHALL decrement on each frame_tick.
- When a frame_tick finds the counter at 1, the FSM SHALL go to PLAY, increment wave (saturating at 255) and pulse wave_init for one cycle.
- With CLEAR_FRAMES=0, the FSM SHALL return to PLAY on the first frame_tick.
REQ-013 OVER: score, lives and wave SHALL hold; a press SHALL move the FSM to IDLE (score retained for display until the next start).
- A new game therefore requires two distinct presses.
REQ-014 wave_init SHALL never be high for two consecutive cycles and SHALL be 0 in every cycle not named in REQ-005 or REQ-012.

Reset
REQ-015 When resetn=0 at a clock edge, the following SHALL be cleared:
- state=IDLE, game_active=0, wave_init=0, score=0, lives=0, wave=0.
- Frame counter, armed flag, start_btn register and enemy_dead_prev SHALL be 0.
REQ-016 Reset SHALL override every other event in the same cycle, including mid-wave or mid-WAVE_CLEAR; no wave_init pulse SHALL be emitted on reset.

Structure
REQ-017 State encodings, the default NUM_ENEMY1, score width (16) and wave width (8) SHALL live in a shared game package used by the game top level and this block.
REQ-018 The rising-edge popcount of REQ-007 SHALL be a combinational sub-module named edge_popcount, parameterised by NUM_ENEMY1 with a 4-bit count output.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset then start: resetn low 2 cycles, then press start -> next edge state=1, game_active=1, wave_init high exactly 1 cycle, score=0, lives=3, wave=1.
- Multi-kill: in PLAY, enemy_dead goes 000000->000111 in one cycle -> score +3 next edge; holding 000111 adds nothing more.
- Wave clear: armed, enemy_dead=111111 -> state=2, game_active=0; after 60 frame_ticks -> state=1, wave=2, one wave_init pulse; held-high dead flags are not re-cleared before the next frame_tick.
- Death priority: lives=1, ship_hit and last enemy death in the same cycle -> state=3, lives=0, score +1.
- Saturation: score=16'hFFFE and 3 new kills -> score=16'hFFFF.
- Reset mid-operation: resetn=0 during WAVE_CLEAR with counter=30 -> state=0, all outputs 0, no wave_init.
